// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if
//   Bundles the requester handshakes and the multiplier operand/product
//   signals of mult_share_arb.
//   slave  : the arbiter side (consumes requests, drives grants, responses
//            and multiplier operands, receives the product).
//   master : the environment side (requesters plus the external multiplier).
//   Optional MULT_SHARE_ARB_STATS_EN adds stat_issued / stat_contend.
interface mult_share_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_a;
  logic [NREQ*W-1:0]     req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*2*W-1:0]   rsp_data;
  logic [W-1:0]          mul_a;
  logic [W-1:0]          mul_b;
  logic [2*W-1:0]        mul_prod;
  logic                  busy;
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0]           stat_issued;
  logic [31:0]           stat_contend;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_prod,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy,
    output stat_issued, stat_contend
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_prod,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy,
    input  stat_issued, stat_contend
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_prod,
    output req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_prod,
    input  req_ready, rsp_valid, rsp_data, mul_a, mul_b, busy
  );
`endif
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb
//   Round-robin arbiter/sequencer sharing one external pipelined multiplier
//   (MUL_LAT cycles from operand-present to product) among NREQ requesters.
//   Each requester has at most one operation outstanding; products return
//   through a held per-requester response register (valid/ready).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : mult_share_arb_if.slave (req_*, rsp_*, mul_a/mul_b/mul_prod,
//               busy, and stat_* when enabled)
// Optional: define MULT_SHARE_ARB_STATS_EN for saturating grant / contention
//   counters (stat_issued, stat_contend).
module mult_share_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mult_share_arb_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = 2 * W;

  logic [NREQ-1:0]              r_inflight;
  logic [NREQ-1:0]              r_rsp_valid;
  logic [NREQ*PW-1:0]           r_rsp_data;
  logic [IW-1:0]                r_ptr;
  logic [MUL_LAT-1:0]           r_tag_v;
  logic [MUL_LAT-1:0][IW-1:0]   r_tag_id;

  logic [NREQ-1:0]              w_eligible;
  logic [NREQ-1:0]              w_grant;
  logic [NREQ-1:0]              w_cap_hit;
  logic                         w_gnt_v;
  logic [IW-1:0]                w_gnt_id;
  logic [IW-1:0]                w_idx;
  logic [IW-1:0]                w_ptr_nxt;

  // A pending response also blocks eligibility, so a returning product
  // always finds its response slot empty.
  assign w_eligible = bus.req_valid & ~r_inflight & ~r_rsp_valid;

  // Rotating priority search starting at the pointer.
  always_comb begin
    w_grant  = '0;
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IW'((r_ptr + k) % NREQ);
      if (!w_gnt_v && w_eligible[w_idx] && !rst) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (w_gnt_v) w_grant[w_gnt_id] = 1'b1;
  end

  assign w_ptr_nxt = IW'((w_gnt_id + 1) % NREQ);

  // Operands go straight to the multiplier, which registers them itself.
  assign bus.mul_a = w_gnt_v ? bus.req_a[w_gnt_id*W +: W] : '0;
  assign bus.mul_b = w_gnt_v ? bus.req_b[w_gnt_id*W +: W] : '0;

  always_comb begin
    w_cap_hit = '0;
    if (r_tag_v[MUL_LAT-1]) w_cap_hit[r_tag_id[MUL_LAT-1]] = 1'b1;
  end

  // Tag pipeline mirrors the multiplier's latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_gnt_v;
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_inflight  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_gnt_v) r_ptr <= w_ptr_nxt;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (w_grant[k])        r_inflight[k] <= 1'b1;
        else if (w_cap_hit[k]) r_inflight[k] <= 1'b0;

        if (w_cap_hit[k]) begin
          r_rsp_valid[k]            <= 1'b1;
          r_rsp_data[k*PW +: PW]    <= bus.mul_prod;
        end else if (r_rsp_valid[k] && bus.rsp_ready[k]) begin
          r_rsp_valid[k]            <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = (|r_inflight) | (|r_rsp_valid);

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_contend;
  logic [IW:0] w_elig_cnt;
  logic        w_contend;

  always_comb begin
    w_elig_cnt = '0;
    for (int unsigned k = 0; k < NREQ; k++)
      w_elig_cnt = w_elig_cnt + (IW+1)'(w_eligible[k]);
    w_contend = (w_elig_cnt >= (IW+1)'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_issued  <= '0;
      r_stat_contend <= '0;
    end else begin
      if (w_gnt_v && (r_stat_issued != '1))    r_stat_issued  <= r_stat_issued + 32'd1;
      if (w_contend && (r_stat_contend != '1)) r_stat_contend <= r_stat_contend + 32'd1;
    end
  end

  assign bus.stat_issued  = r_stat_issued;
  assign bus.stat_contend = r_stat_contend;
`endif
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
//   Self-checking bench for mult_share_arb with a 2-stage multiplier model.
//   Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_mult_share_arb;
  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;
  localparam int unsigned PW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;
  exp_t sb_q[$];

  mult_share_arb_if #(.NREQ(NREQ), .W(W)) bus();

  mult_share_arb #(.NREQ(NREQ), .W(W), .MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External multiplier: registered inputs, registered product.
  logic [W-1:0]  r_ma, r_mb;
  logic [PW-1:0] r_mp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma <= '0;
      r_mb <= '0;
      r_mp <= '0;
    end else begin
      r_ma <= bus.mul_a;
      r_mb <= bus.mul_b;
      r_mp <= {16'b0, r_ma} * {16'b0, r_mb};
    end
  end
  assign bus.mul_prod = r_mp;

  // Scoreboard: push on accepted request, pop on consumed response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[k] && bus.req_ready[k]) begin
          exp_t e;
          e.id   = k;
          e.prod = {16'b0, bus.req_a[k*W +: W]} * {16'b0, bus.req_b[k*W +: W]};
          sb_q.push_back(e);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (bus.rsp_valid[k] && bus.rsp_ready[k]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sb_q.size(); j++)
            if (idx < 0 && sb_q[j].id == k) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL sb_unexpected_rsp[%0d]: got data %h, expected no response", k, bus.rsp_data[k*PW +: PW]);
          end else begin
            if (bus.rsp_data[k*PW +: PW] !== sb_q[idx].prod) begin
              errors++;
              $display("FAIL sb_data[%0d]: got %h expected %h", k, bus.rsp_data[k*PW +: PW], sb_q[idx].prod);
            end
            sb_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp: got valid %b data %h expected 0", bus.rsp_valid, bus.rsp_data); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL post_reset_idle: got busy %b ready %b expected 0 0000", bus.busy, bus.req_ready); end
  endtask

  task automatic test_single();
    step();
    bus.req_valid = 4'b0100;
    bus.req_a[2*W +: W] = 16'h1234;
    bus.req_b[2*W +: W] = 16'h0010;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", bus.req_ready); end
    checks++;
    if (bus.mul_a !== 16'h1234 || bus.mul_b !== 16'h0010) begin errors++; $display("FAIL single_operands: got %h/%h expected 1234/0010", bus.mul_a, bus.mul_b); end
    step();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1 || bus.mul_a !== 16'h0000) begin errors++; $display("FAIL single_c1: got rsp %b busy %b mul_a %h expected 0000 1 0000", bus.rsp_valid, bus.busy, bus.mul_a); end
    step();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_c2: got rsp %b expected 0000", bus.rsp_valid); end
    step();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_c3_valid: got %b expected 0100", bus.rsp_valid); end
    checks++;
    if (bus.rsp_data[2*PW +: PW] !== 32'h00012340) begin errors++; $display("FAIL single_c3_data: got %h expected 00012340", bus.rsp_data[2*PW +: PW]); end
    step();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_c4_clear: got rsp %b busy %b expected 0000 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_max();
    bit ok;
    step();
    bus.req_valid = 4'b0001;
    bus.req_a[0 +: W] = 16'hFFFF;
    bus.req_b[0 +: W] = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL max_grant: got %b expected 0001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    wait_rsp(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL max_timeout: got no rsp_valid[0] expected one within 10 cycles"); end
    else if (bus.rsp_data[0 +: PW] !== 32'hFFFE0001) begin errors++; $display("FAIL max_data: got %h expected fffe0001", bus.rsp_data[0 +: PW]); end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    bus.rsp_ready = '1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      logic [3:0] exp_g;
      step();
      bus.req_valid = '1;
      bus.req_a = {$urandom, $urandom};
      bus.req_b = {$urandom, $urandom};
      exp_g = 4'b0001 << (cyc % 4);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp_g) begin errors++; $display("FAIL contention_grant[%0d]: got %b expected %b", cyc, bus.req_ready, exp_g); end
    end
    step();
    bus.req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin errors++; $display("FAIL contention_drain: got busy-clear %0d pending %0d expected 1 0", ok, sb_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bus.rsp_ready = 4'b1101;
    for (int cyc = 0; cyc < 16; cyc++) begin
      logic [3:0] exp_g;
      step();
      bus.req_valid = '1;
      bus.req_a = {$urandom, $urandom};
      bus.req_b = {$urandom, $urandom};
      if (cyc < 5) exp_g = 4'b0001 << (cyc % 4);
      else begin
        case ((cyc - 5) % 4)
          0:       exp_g = 4'b0000;
          1:       exp_g = 4'b0100;
          2:       exp_g = 4'b1000;
          default: exp_g = 4'b0001;
        endcase
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp_g) begin errors++; $display("FAIL bp_grant[%0d]: got %b expected %b", cyc, bus.req_ready, exp_g); end
      if (cyc >= 4) begin
        checks++;
        if (bus.rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got rsp_valid[1]=%b expected 1", cyc, bus.rsp_valid[1]); end
      end
    end
    step();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = '1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_consume_cycle: got %b expected 0000", bus.req_ready); end
    step();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_reenable: got %b expected 0010", bus.req_ready); end
    step();
    bus.req_valid = '0;
    drain(ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin errors++; $display("FAIL bp_drain: got busy-clear %0d pending %0d expected 1 0", ok, sb_q.size()); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    logic [31:0] exp3;
    do_reset();
    step();
    bus.req_valid = 4'b1001;
    bus.req_a[0 +: W] = 16'h1111; bus.req_b[0 +: W] = 16'h2222;
    bus.req_a[3*W +: W] = 16'h3333; bus.req_b[3*W +: W] = 16'h4444;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmf_grant0: got %b expected 0001", bus.req_ready); end
    step();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rmf_grant3: got %b expected 1000", bus.req_ready); end
    step();
    rst = 1'b1;
    bus.req_valid = '0;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmf_in_reset: got busy %b rsp %b expected 0 0000", bus.busy, bus.rsp_valid); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmf_after[%0d]: got busy %b rsp %b expected 0 0000", i, bus.busy, bus.rsp_valid); end
    end
    step();
    bus.req_valid = 4'b1010;
    bus.req_a[1*W +: W] = 16'h0007; bus.req_b[1*W +: W] = 16'h0009;
    bus.req_a[3*W +: W] = 16'hBEEF; bus.req_b[3*W +: W] = 16'h1357;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rmf_lowest_first: got %b expected 0010", bus.req_ready); end
    step();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rmf_grant3_again: got %b expected 1000", bus.req_ready); end
    step();
    bus.req_valid = '0;
    exp3 = 32'h0000BEEF * 32'h00001357;
    wait_rsp(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmf_timeout: got no rsp_valid[3] expected one within 10 cycles"); end
    else if (bus.rsp_data[3*PW +: PW] !== exp3) begin errors++; $display("FAIL rmf_data3: got %h expected %h", bus.rsp_data[3*PW +: PW], exp3); end
    drain(ok);
    checks++;
    if (!ok || sb_q.size() != 0) begin errors++; $display("FAIL rmf_drain: got busy-clear %0d pending %0d expected 1 0", ok, sb_q.size()); end
  endtask

`ifdef MULT_SHARE_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    bus.rsp_ready = '1;
    @(negedge clk);
    checks++;
    if (bus.stat_issued !== 32'd0 || bus.stat_contend !== 32'd0) begin errors++; $display("FAIL stats_init: got %0d/%0d expected 0/0", bus.stat_issued, bus.stat_contend); end
    // 4 grants, 3 contended cycles
    for (int i = 0; i < 4; i++) begin
      step();
      bus.req_valid = '1;
    end
    step();
    bus.req_valid = '0;
    drain(ok);
    // 2 grants, 1 contended cycle
    step();
    bus.req_valid = 4'b0011;
    step();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    drain(ok);
    // 4 uncontended grants
    for (int i = 0; i < 4; i++) begin
      step();
      bus.req_valid = 4'b0001 << i;
    end
    step();
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.stat_issued !== 32'd10) begin errors++; $display("FAIL stats_issued: got %0d expected 10", bus.stat_issued); end
    checks++;
    if (bus.stat_contend !== 32'd4) begin errors++; $display("FAIL stats_contend: got %0d expected 4", bus.stat_contend); end
    drain(ok);
    step();
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (bus.stat_issued !== 32'd0 || bus.stat_contend !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", bus.stat_issued, bus.stat_contend); end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
    test_reset();
    test_single();
    test_max();
    test_contention();
    test_backpressure();
    test_reset_midflight();
`ifdef MULT_SHARE_ARB_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 16x16 unsigned multiplier among NREQ requesters.
- The multiplier registers its inputs and its product, giving 2-cycle latency; it is instantiated outside this block on the same clk/rst.
- This block selects one requester per cycle and drives the operands to the multiplier.
- It tracks in-flight operations with a tag pipeline and returns each product to the requester that issued it, through a held response register with a valid/ready handshake.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; the product is 2*W.
- MUL_LAT, 2, cycles from the operand-present cycle to the product appearing on mul_prod.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; the operation is accepted when req_valid[i]&req_ready[i]
- req_a  in  NREQ*W  operand A, slice i belongs to requester i
- req_b  in  NREQ*W  operand B
- rsp_valid  out  NREQ  product held for requester i
- rsp_ready  in  NREQ  requester i consumes its product
- rsp_data  out  NREQ*2W  product, slice i
- mul_a  out  W  to multiplier inp_a
- mul_b  out  W  to multiplier inp_b
- mul_prod  in  2W  from multiplier prod
- busy  out  1  any operation in flight or any response pending

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - rsp_valid=0, rsp_data=0.
  - Tag pipeline cleared; inflight[]=0; round-robin pointer=0.
  - req_ready=0 while rst is asserted; busy=0.
- Eligibility: eligible[i] = req_valid[i] & ~inflight[i] & ~rsp_valid[i]. At most one outstanding operation per requester. This guarantees a response slot is always free when its product returns, so no response overflow is possible.
- Arbitration:
  - Combinational. Search eligible[] starting at the pointer, wrapping modulo NREQ. The first hit gets req_ready.
  - At most one grant per cycle; req_ready is 0 for non-eligible requesters.
  - On a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Operand drive:
  - In the grant cycle, mul_a and mul_b equal the granted requester's slices.
  - With no grant, both are 0.
  - No register sits between the arbiter and the multiplier; the multiplier flops them itself.
- Tag pipeline:
  - MUL_LAT stages of {valid, id[$clog2(NREQ)-1:0]}.
  - Stage 0 is loaded with {grant, id} at the edge ending the grant cycle; stages shift every cycle.
  - inflight[id] is set on the grant and cleared at the edge where that tag's product is captured.
- Capture:
  - When the last stage is valid with id=k, mul_prod is written into rsp_data[k] at the end of that cycle and rsp_valid[k] is set.
  - Request-to-response latency is MUL_LAT+1 cycles: grant in cycle c, rsp_valid high from cycle c+3 for MUL_LAT=2.
  - Sustained throughput is one product per cycle when different requesters alternate.
- Response handshake:
  - rsp_valid[k] and rsp_data[k] hold until rsp_valid[k]&rsp_ready[k]; rsp_valid[k] clears at that edge.
  - A requester is not eligible in the cycle its response is consumed; it becomes eligible the following cycle.
- Arithmetic: unsigned, with full 2W-bit product passthrough. The block itself does no arithmetic.
- Boundary cases:
  - All requesters valid: strict rotation 0,1,2,3,0,... for requesters whose responses are consumed promptly.
  - A requester that never asserts rsp_ready blocks only itself; the others continue.
  - req_valid deasserting without a grant is legal; there is no penalty.
  - Operand slices must be stable only during the grant cycle.
- Reset mid-operation: in-flight tags and pending responses are discarded, and the multiplier pipe is also cleared by rst. The first grant after reset goes to the lowest eligible index.
- busy = |inflight | |rsp_valid.

Optional Feature:
- Macro: MULT_SHARE_ARB_STATS_EN.
- When defined, adds two output ports:
  - stat_issued (32-bit): count of grants.
  - stat_contend (32-bit): count of cycles with two or more eligible requesters.
- Both counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Single op: requester 2 sends a=0x1234, b=0x0010 in cycle 5 with rsp_ready=1. req_ready[2]=1 in cycle 5; rsp_valid[2]=1 with rsp_data[2]=0x00012340 in cycle 8; it clears after one cycle.
- Max values: a=0xFFFF, b=0xFFFF from requester 0. rsp_data[0]=0xFFFE0001.
- Contention: all 4 requesters valid continuously, rsp_ready=1, pointer=0 after reset. Grants go 0,1,2,3, and every requester is granted again after its response clears. Each product is routed to the correct slice; checked against a scoreboard of issued operands.
- Backpressure: requester 1 holds rsp_ready=0 after its first result. req_ready[1] stays 0 while the other requesters keep being granted. Raising rsp_ready re-enables requester 1 one cycle after consumption.
- Reset mid-flight: assert rst one cycle after grants to requesters 0 and 3. rsp_valid stays 0 and busy=0 after release. The next request from requester 3 completes with correct data.
- Stats (MULT_SHARE_ARB_STATS_EN): 10 grants with 4 contended cycles. stat_issued=10, stat_contend=4; both return to 0 on rst.
